// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Summary  : Opcode encodings, instruction field positions, FSM state type and
//            the per-opcode execution latency lookup.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

  localparam int c_instr_w = 12;

  localparam int c_op_msb  = 11;
  localparam int c_op_lsb  = 9;
  localparam int c_rd_msb  = 8;
  localparam int c_rd_lsb  = 6;
  localparam int c_rs1_msb = 5;
  localparam int c_rs1_lsb = 3;
  localparam int c_rs2_msb = 2;
  localparam int c_rs2_lsb = 0;

  localparam logic [2:0] c_op_nop  = 3'b000;
  localparam logic [2:0] c_op_add  = 3'b001;
  localparam logic [2:0] c_op_sub  = 3'b010;
  localparam logic [2:0] c_op_mul  = 3'b011;
  localparam logic [2:0] c_op_imul = 3'b100;
  localparam logic [2:0] c_op_fadd = 3'b101;
  localparam logic [2:0] c_op_fmul = 3'b110;
  localparam logic [2:0] c_op_cmp  = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } seq_state_t;

  // Cycles from the issue_valid cycle to the wb_en cycle; NOP never issues.
  function automatic logic [2:0] op_latency(input logic [2:0] op);
    logic [2:0] lat;
    lat = 3'd1;
    case (op)
      c_op_add, c_op_sub, c_op_cmp: lat = 3'd1;
      c_op_mul, c_op_imul:          lat = 3'd3;
      c_op_fadd:                    lat = 3'd4;
      c_op_fmul:                    lat = 3'd5;
      default:                      lat = 3'd1;
    endcase
    return lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : instr_fifo
// Summary  : Power-of-two instruction FIFO with occupancy count, no bypass.
// Revision : 1.0
// ============================================================================
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Summary  : In-order single-issue sequencer: buffers instructions, issues one
//            at a time and signals writeback after the opcode's latency.
// Revision : 1.0
// ============================================================================
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [11:0]            instr,
  output logic                   issue_valid,
  output logic [2:0]             issue_op,
  output logic [2:0]             issue_rd,
  output logic [2:0]             issue_rs1,
  output logic [2:0]             issue_rs2,
  output logic                   wb_en,
  output logic [2:0]             wb_rd,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  seq_state_t             r_state;
  logic [2:0]             r_lat_cnt;
  logic [c_instr_w-1:0]   w_head;
  logic [2:0]             w_head_op;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_slot;
  logic                   w_pop;
  logic                   w_issue;

  assign w_push      = instr_valid && !w_full;
  assign w_head_op   = w_head[c_op_msb:c_op_lsb];
  // The unit is free to take the head when idle or in its writeback cycle.
  assign w_slot      = (r_state == IDLE) || wb_en;
  assign w_pop       = w_slot && !w_empty;
  assign w_issue     = w_pop && (w_head_op != c_op_nop);
  assign instr_ready = !w_full;
  assign busy        = !w_empty || (r_state == EXEC);

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_instr_w)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (instr),
    .dout  (w_head),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lat_cnt   <= '0;
      issue_valid <= 1'b0;
      issue_op    <= '0;
      issue_rd    <= '0;
      issue_rs1   <= '0;
      issue_rs2   <= '0;
      wb_en       <= 1'b0;
      wb_rd       <= '0;
    end else begin
      issue_valid <= 1'b0;
      wb_en       <= 1'b0;
      if (w_issue) begin
        r_state     <= EXEC;
        issue_valid <= 1'b1;
        issue_op    <= w_head_op;
        issue_rd    <= w_head[c_rd_msb:c_rd_lsb];
        issue_rs1   <= w_head[c_rs1_msb:c_rs1_lsb];
        issue_rs2   <= w_head[c_rs2_msb:c_rs2_lsb];
        r_lat_cnt   <= op_latency(w_head_op) - 3'd1;
      end else if (r_state == EXEC) begin
        if (wb_en) begin
          r_state <= IDLE;
        end else if (r_lat_cnt == 3'd0) begin
          wb_en <= 1'b1;
          wb_rd <= issue_rd;
        end else begin
          r_lat_cnt <= r_lat_cnt - 3'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, instruction FIFO depth in entries (power of two, >=2).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 instr_valid  input  1  producer offers instr this cycle.
REQ-005 instr_ready  output  1  sequencer can accept instr this cycle.
REQ-006 instr  input  12  [11:9] opcode, [8:6] rd, [5:3] rs1, [2:0] rs2.
REQ-007 issue_valid  output  1  one-cycle pulse starting the datapath operation.
REQ-008 issue_op  output  3  opcode of the issued instruction.
REQ-009 issue_rd, issue_rs1, issue_rs2  output  3 each  register fields of the issued instruction.
REQ-010 wb_en  output  1  one-cycle pulse: result of the issued instruction is written back.
REQ-011 wb_rd  output  3  destination register for wb_en.
REQ-012 busy  output  1  high while FIFO is non-empty or an instruction is in flight.
REQ-013 fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 Opcodes: 000 NOP, 001 ADD, 010 SUB, 011 MUL, 100 IMUL, 101 FADD, 110 FMUL, 111 CMP.
REQ-015 Latency LAT: ADD/SUB/CMP 1, MUL/IMUL 3, FADD 4, FMUL 5 cycles.
REQ-016 Accept on instr_valid && instr_ready; instr_ready = (fifo_count < DEPTH), no pop-bypass when full.
REQ-017 No input-to-issue bypass; an instruction accepted at edge E pops no earlier than edge E+1.
REQ-018 FSM states IDLE, EXEC; single instruction in flight, strict in-order.
REQ-019 IDLE, FIFO non-empty, head opcode != 000: pop at edge P, enter EXEC, issue_valid high in the cycle after P.
REQ-020 IDLE, head opcode 000: pop and discard at edge P, remain IDLE, no issue_valid or wb_en.
REQ-021 EXEC: wb_en high exactly LAT cycles after the issue_valid cycle, wb_rd = issue_rd, for one cycle.
REQ-022 At the edge ending the wb_en cycle: if FIFO non-empty, pop next (REQ-019/020 rules), else return to IDLE.
REQ-023 Back-to-back ADDs therefore issue every 2 cycles; FMULs every 6.
REQ-024 issue_op/rd/rs1/rs2 held stable from issue_valid cycle through the wb_en cycle inclusive.
REQ-025 Simultaneous push and pop in one cycle: count unchanged, both take effect.
REQ-026 FIFO pointers wrap modulo DEPTH; no loss or duplication across wrap.
REQ-027 All outputs registered; instr_ready and busy derived from registered state only.

Reset
REQ-028 rst_n low: FSM IDLE, FIFO emptied, fifo_count 0, issue_valid 0, wb_en 0, all field outputs 0, busy 0, instr_ready 1.
REQ-029 Reset during EXEC abandons the in-flight instruction; no wb_en after rst_n deasserts until a new issue.

Structure
REQ-030 Shared package cpu_pkg holds opcode constants, instruction field bit positions and the latency lookup function.
REQ-031 FIFO implemented as sub-module instr_fifo (parameter DEPTH, 12-bit data, push/pop/count).

Verification
REQ-032 Reset: rst_n low mid-stream -> all outputs 0, instr_ready 1 next cycle and while held.
REQ-033 Push ADD R2,R0,R1 (0x281) into idle empty unit at edge E -> issue_valid cycle after E+1, op 1, rd 2, rs1 0, rs2 1; wb_en, wb_rd 2 one cycle later.
REQ-034 Push FMUL R7,R5,R6 (0xDEE) -> wb_en 5 cycles after issue_valid, wb_rd 7; fields stable throughout.
REQ-035 Push MUL R4,R0,R1 (0x701) on 6 consecutive cycles -> instr_ready low while fifo_count 4, exactly 6 issue/wb pairs, 4-cycle spacing, no loss.
REQ-036 Push 0x281, 0x000, 0xE88 -> only two issue_valid pulses (op 1 then op 7), wb_rd 2 then 2.
REQ-037 Push FADD R7,R5,R6 (0xBEE), assert rst_n low 2 cycles after issue_valid -> no wb_en, fifo_count 0, busy 0.
